williams_ps2_keymap: RTL and testbench

//  Upstream input stage of the Williams arcade top level. Consumes the hps_io
//  ps2_key event word and keeps a per-key held state. Produces the 20 registered

---
 rtl/williams_ps2_keymap.sv | 214 +++++++++++++++++++++
 tb/tb_williams_ps2_keymap.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/williams_ps2_keymap.sv
// williams_ps2_keymap: turns the hps_io ps2_key event word into 20 registered
// button levels for the Williams arcade top level. Aliased keys each keep their
// own held bit and are ORed into the button. Coin buttons are pulse-stretched
// so that a short tap still lasts long enough for the game's slow coin sampling.
// Optional feature: define WILLIAMS_AUTOFIRE_EN to build the autofire
// oscillator on fireA/fire2A; without it the autofire input is ignored.
module williams_ps2_keymap #(
    parameter int COIN_HOLD = 600000,
    parameter int COIN_W    = 20,
    parameter int AF_PERIOD = 200000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        clear_all,
    input  logic        autofire,
    output logic [19:0] btn,
    output logic        key_hit
);

    // Held-state bit positions; the aliased keys get one bit per physical key.
    localparam int NRAW = 23;
    localparam logic [4:0] R_UP   = 5'd0;
    localparam logic [4:0] R_DN   = 5'd1;
    localparam logic [4:0] R_LT   = 5'd2;
    localparam logic [4:0] R_RT   = 5'd3;
    localparam logic [4:0] R_FA   = 5'd4;
    localparam logic [4:0] R_FB   = 5'd5;
    localparam logic [4:0] R_FC   = 5'd6;
    localparam logic [4:0] R_FD   = 5'd7;
    localparam logic [4:0] R_ST1A = 5'd8;
    localparam logic [4:0] R_ST1B = 5'd9;
    localparam logic [4:0] R_ST2A = 5'd10;
    localparam logic [4:0] R_ST2B = 5'd11;
    localparam logic [4:0] R_C1A  = 5'd12;
    localparam logic [4:0] R_C1B  = 5'd13;
    localparam logic [4:0] R_C2   = 5'd14;
    localparam logic [4:0] R_UP2  = 5'd15;
    localparam logic [4:0] R_DN2  = 5'd16;
    localparam logic [4:0] R_LT2  = 5'd17;
    localparam logic [4:0] R_RT2  = 5'd18;
    localparam logic [4:0] R_F2A  = 5'd19;
    localparam logic [4:0] R_F2B  = 5'd20;
    localparam logic [4:0] R_F2C  = 5'd21;
    localparam logic [4:0] R_F2D  = 5'd22;

    localparam logic [COIN_W-1:0] COIN_LOAD = COIN_W'(COIN_HOLD);

    logic              tog_q;
    logic              primed_q;
    logic [NRAW-1:0]   raw_q;
    logic [NRAW-1:0]   raw_next;
    logic [COIN_W-1:0] cnt1_q, cnt1_next;
    logic [COIN_W-1:0] cnt2_q, cnt2_next;
    logic              coin1_or_q, coin1_or_next;
    logic              coin2_or_next;
    logic              evt;
    logic              mapped;
    logic [4:0]        raw_idx;
    logic              fire_a_lvl;
    logic              fire2_a_lvl;
    logic [19:0]       btn_next;
    logic              unused_in;

    // The extended flag is deliberately ignored so E0 arrows alias the plain codes.
    assign evt = primed_q && (ps2_key[10] != tog_q);

    // Scan code to held-state bit lookup.
    always_comb begin
        mapped  = 1'b1;
        raw_idx = R_UP;
        case (ps2_key[7:0])
            8'h75: raw_idx = R_UP;
            8'h72: raw_idx = R_DN;
            8'h6B: raw_idx = R_LT;
            8'h74: raw_idx = R_RT;
            8'h14: raw_idx = R_FA;
            8'h11: raw_idx = R_FB;
            8'h29: raw_idx = R_FC;
            8'h12: raw_idx = R_FD;
            8'h05: raw_idx = R_ST1A;
            8'h16: raw_idx = R_ST1B;
            8'h06: raw_idx = R_ST2A;
            8'h1E: raw_idx = R_ST2B;
            8'h76: raw_idx = R_C1A;
            8'h2E: raw_idx = R_C1B;
            8'h36: raw_idx = R_C2;
            8'h2D: raw_idx = R_UP2;
            8'h2B: raw_idx = R_DN2;
            8'h23: raw_idx = R_LT2;
            8'h34: raw_idx = R_RT2;
            8'h1C: raw_idx = R_F2A;
            8'h1B: raw_idx = R_F2B;
            8'h21: raw_idx = R_F2C;
            8'h1D: raw_idx = R_F2D;
            default: mapped = 1'b0;
        endcase
    end

    // Next held state and coin stretch counters; clear_all wins over an event.
    always_comb begin
        raw_next = raw_q;
        if (clear_all)
            raw_next = '0;
        else if (evt && mapped)
            raw_next[raw_idx] = ps2_key[9];

        coin1_or_q    = raw_q[R_C1A] | raw_q[R_C1B];
        coin1_or_next = raw_next[R_C1A] | raw_next[R_C1B];
        coin2_or_next = raw_next[R_C2];

        cnt1_next = cnt1_q;
        if (clear_all)
            cnt1_next = '0;
        else if (coin1_or_next && !coin1_or_q)
            cnt1_next = COIN_LOAD;
        else if (cnt1_q != '0)
            cnt1_next = cnt1_q - COIN_W'(1);

        cnt2_next = cnt2_q;
        if (clear_all)
            cnt2_next = '0;
        else if (coin2_or_next && !raw_q[R_C2])
            cnt2_next = COIN_LOAD;
        else if (cnt2_q != '0)
            cnt2_next = cnt2_q - COIN_W'(1);
    end

`ifdef WILLIAMS_AUTOFIRE_EN
    localparam int AF_W = $clog2(AF_PERIOD + 1);

    logic [AF_W-1:0] af_cnt_q, af_cnt_next;
    logic            af_ph_q, af_ph_next;

    // Free-running half-period counter; the phase flips each time it wraps.
    always_comb begin
        af_cnt_next = af_cnt_q + AF_W'(1);
        af_ph_next  = af_ph_q;
        if (clear_all) begin
            af_cnt_next = '0;
            af_ph_next  = 1'b0;
        end else if (af_cnt_q == AF_W'(AF_PERIOD - 1)) begin
            af_cnt_next = '0;
            af_ph_next  = ~af_ph_q;
        end
        fire_a_lvl  = (autofire && raw_next[R_FA])  ? af_ph_next : raw_next[R_FA];
        fire2_a_lvl = (autofire && raw_next[R_F2A]) ? af_ph_next : raw_next[R_F2A];
    end

    // Autofire oscillator state.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt_q <= '0;
            af_ph_q  <= 1'b0;
        end else begin
            af_cnt_q <= af_cnt_next;
            af_ph_q  <= af_ph_next;
        end
    end

    assign unused_in = ps2_key[8];
`else
    assign fire_a_lvl  = raw_next[R_FA];
    assign fire2_a_lvl = raw_next[R_F2A];
    assign unused_in   = ^{ps2_key[8], autofire, 32'(AF_PERIOD)};
`endif

    // Assemble the button word from the next held state so outputs lag input by one edge.
    always_comb begin
        btn_next        = '0;
        btn_next[0]     = raw_next[R_UP];
        btn_next[1]     = raw_next[R_DN];
        btn_next[2]     = raw_next[R_LT];
        btn_next[3]     = raw_next[R_RT];
        btn_next[4]     = fire_a_lvl;
        btn_next[5]     = raw_next[R_FB];
        btn_next[6]     = raw_next[R_FC];
        btn_next[7]     = raw_next[R_FD];
        btn_next[8]     = raw_next[R_ST1A] | raw_next[R_ST1B];
        btn_next[9]     = raw_next[R_ST2A] | raw_next[R_ST2B];
        btn_next[10]    = coin1_or_next | (cnt1_next != '0);
        btn_next[11]    = coin2_or_next | (cnt2_next != '0);
        btn_next[12]    = raw_next[R_UP2];
        btn_next[13]    = raw_next[R_DN2];
        btn_next[14]    = raw_next[R_LT2];
        btn_next[15]    = raw_next[R_RT2];
        btn_next[16]    = fire2_a_lvl;
        btn_next[17]    = raw_next[R_F2B];
        btn_next[18]    = raw_next[R_F2C];
        btn_next[19]    = raw_next[R_F2D];
    end

    // Event tracking, held state, coin counters and registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q    <= 1'b0;
            primed_q <= 1'b0;
            raw_q    <= '0;
            cnt1_q   <= '0;
            cnt2_q   <= '0;
            btn      <= '0;
            key_hit  <= 1'b0;
        end else begin
            tog_q    <= ps2_key[10];
            primed_q <= 1'b1;
            raw_q    <= raw_next;
            cnt1_q   <= cnt1_next;
            cnt2_q   <= cnt2_next;
            btn      <= btn_next;
            key_hit  <= evt && mapped && !clear_all;
        end
    end

endmodule

// File: tb/tb_williams_ps2_keymap.sv
// Testbench for williams_ps2_keymap: a scan-code level model runs alongside the
// DUT and is compared every cycle, plus directed scenarios with literal values.
module tb_williams_ps2_keymap;

    localparam int COIN_HOLD = 8;
    localparam int COIN_W    = 4;
    localparam int AF_PERIOD = 4;

    logic        clk_sys;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        clear_all;
    logic        autofire;
    logic [19:0] btn;
    logic        key_hit;

    int checks   = 0;
    int failures = 0;

    williams_ps2_keymap #(
        .COIN_HOLD(COIN_HOLD),
        .COIN_W   (COIN_W),
        .AF_PERIOD(AF_PERIOD)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_key  (ps2_key),
        .clear_all(clear_all),
        .autofire (autofire),
        .btn      (btn),
        .key_hit  (key_hit)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Which button a scan code drives, or -1 when it is not mapped.
    function automatic int btn_of(input logic [7:0] c);
        case (c)
            8'h75: return 0;   8'h72: return 1;   8'h6B: return 2;   8'h74: return 3;
            8'h14: return 4;   8'h11: return 5;   8'h29: return 6;   8'h12: return 7;
            8'h05: return 8;   8'h16: return 8;   8'h06: return 9;   8'h1E: return 9;
            8'h76: return 10;  8'h2E: return 10;  8'h36: return 11;
            8'h2D: return 12;  8'h2B: return 13;  8'h23: return 14;  8'h34: return 15;
            8'h1C: return 16;  8'h1B: return 17;  8'h21: return 18;  8'h1D: return 19;
            default: return -1;
        endcase
    endfunction

    // Model state: one held flag per scan code, remaining stretch per coin.
    bit        m_held [256];
    int        m_left [2];
    bit        m_prev [2];
    bit        m_tog;
    bit        m_primed;
    int        m_af_k;
    bit [19:0] exp_btn;
    bit        exp_hit;

    // Behavioural model evaluated at every clock edge.
    always @(posedge clk_sys or negedge reset_n) begin
        bit        ev;
        bit        now;
        int        idx;
        bit [19:0] lvl;
        if (!reset_n) begin
            foreach (m_held[c]) m_held[c] = 1'b0;
            m_left   = '{0, 0};
            m_prev   = '{1'b0, 1'b0};
            m_tog    = 1'b0;
            m_primed = 1'b0;
            m_af_k   = 0;
            exp_btn  = '0;
            exp_hit  = 1'b0;
        end else begin
            ev       = m_primed && (ps2_key[10] != m_tog);
            m_tog    = ps2_key[10];
            m_primed = 1'b1;
            idx      = btn_of(ps2_key[7:0]);
            if (clear_all) begin
                foreach (m_held[c]) m_held[c] = 1'b0;
                m_af_k  = 0;
                exp_hit = 1'b0;
            end else begin
                if (ev && idx >= 0) m_held[ps2_key[7:0]] = ps2_key[9];
                exp_hit = ev && (idx >= 0);
                m_af_k  = m_af_k + 1;
            end
            lvl = '0;
            for (int c = 0; c < 256; c++)
                if (m_held[c] && btn_of(8'(c)) >= 0) lvl[btn_of(8'(c))] = 1'b1;
            for (int j = 0; j < 2; j++) begin
                now = lvl[10 + j];
                if (clear_all)
                    m_left[j] = 0;
                else if (now && !m_prev[j])
                    m_left[j] = COIN_HOLD;
                else if (m_left[j] > 0)
                    m_left[j] = m_left[j] - 1;
                m_prev[j] = now;
                if (m_left[j] > 0) lvl[10 + j] = 1'b1;
            end
`ifdef WILLIAMS_AUTOFIRE_EN
            if (autofire) begin
                if (lvl[4])  lvl[4]  = ((m_af_k / AF_PERIOD) % 2) == 1;
                if (lvl[16]) lvl[16] = ((m_af_k / AF_PERIOD) % 2) == 1;
            end
`endif
            exp_btn = lvl;
        end
    end

    task automatic checkOutput(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_sys) begin
        if (reset_n) begin
            checkOutput("model_btn", btn, exp_btn);
            checkOutput("model_hit", {19'b0, key_hit}, {19'b0, exp_hit});
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic applyStimulus(input logic p, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], p, ext, code};
        tick();
    endtask

    int n;

    initial begin
        reset_n   = 1'b0;
        ps2_key   = 11'h400;
        clear_all = 1'b0;
        autofire  = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;

        $display("[TB] reset release with toggle high");
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t1_btn", btn, 20'h0);
            checkOutput("t1_hit", {19'b0, key_hit}, 20'h0);
        end

        $display("[TB] single key press/release");
        applyStimulus(1'b1, 1'b0, 8'h75);
        checkOutput("t2_press_btn", btn, 20'h00001);
        checkOutput("t2_press_hit", {19'b0, key_hit}, 20'h1);
        tick();
        checkOutput("t2_hit_once", {19'b0, key_hit}, 20'h0);
        checkOutput("t2_held_btn", btn, 20'h00001);
        applyStimulus(1'b1, 1'b0, 8'h75);
        checkOutput("t2_typematic_hit", {19'b0, key_hit}, 20'h1);
        applyStimulus(1'b0, 1'b0, 8'h75);
        checkOutput("t2_release_btn", btn, 20'h0);
        applyStimulus(1'b1, 1'b1, 8'h74);
        checkOutput("t2_ext_right", btn, 20'h00008);
        applyStimulus(1'b0, 1'b1, 8'h74);
        applyStimulus(1'b1, 1'b0, 8'h1A);
        checkOutput("t2_unmapped_hit", {19'b0, key_hit}, 20'h0);
        checkOutput("t2_unmapped_btn", btn, 20'h0);
        applyStimulus(1'b1, 1'b0, 8'h05);
        applyStimulus(1'b1, 1'b0, 8'h16);
        applyStimulus(1'b0, 1'b0, 8'h05);
        checkOutput("t2_alias_start1", btn, 20'h00100);
        applyStimulus(1'b0, 1'b0, 8'h16);
        checkOutput("t2_alias_start1_off", btn, 20'h0);

        $display("[TB] coin1 aliases");
        applyStimulus(1'b1, 1'b0, 8'h76);
        n = int'(btn[10]);
        applyStimulus(1'b1, 1'b0, 8'h2E);
        n += int'(btn[10]);
        applyStimulus(1'b0, 1'b0, 8'h76);
        n += int'(btn[10]);
        applyStimulus(1'b0, 1'b0, 8'h2E);
        n += int'(btn[10]);
        for (int i = 0; i < 20; i++) begin
            tick();
            n += int'(btn[10]);
        end
        checkOutput("t3_short_len", 20'(n), 20'd8);
        applyStimulus(1'b1, 1'b0, 8'h76);
        applyStimulus(1'b1, 1'b0, 8'h2E);
        applyStimulus(1'b0, 1'b0, 8'h76);
        repeat (12) tick();
        checkOutput("t3_alias_held", btn, 20'h00400);
        applyStimulus(1'b0, 1'b0, 8'h2E);
        checkOutput("t3_alias_release", btn, 20'h0);

        $display("[TB] coin2 tap and re-tap");
        applyStimulus(1'b1, 1'b0, 8'h36);
        n = int'(btn[11]);
        applyStimulus(1'b0, 1'b0, 8'h36);
        n += int'(btn[11]);
        for (int i = 0; i < 20; i++) begin
            tick();
            n += int'(btn[11]);
        end
        checkOutput("t4_tap_len", 20'(n), 20'd8);
        applyStimulus(1'b1, 1'b0, 8'h36);
        applyStimulus(1'b0, 1'b0, 8'h36);
        repeat (3) tick();
        checkOutput("t4_mid_count", btn, 20'h00800);
        applyStimulus(1'b1, 1'b0, 8'h36);
        n = int'(btn[11]);
        applyStimulus(1'b0, 1'b0, 8'h36);
        n += int'(btn[11]);
        for (int i = 0; i < 20; i++) begin
            tick();
            n += int'(btn[11]);
        end
        checkOutput("t4_retap_len", 20'(n), 20'd8);

        $display("[TB] reset mid-count");
        applyStimulus(1'b1, 1'b0, 8'h36);
        applyStimulus(1'b0, 1'b0, 8'h36);
        tick();
        reset_n = 1'b0;
        #1;
        checkOutput("rst_async_btn", btn, 20'h0);
        checkOutput("rst_async_hit", {19'b0, key_hit}, 20'h0);
        ps2_key = 11'h675;
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_primed_btn", btn, 20'h0);
            checkOutput("rst_primed_hit", {19'b0, key_hit}, 20'h0);
        end

        $display("[TB] clear_all with concurrent event");
        applyStimulus(1'b1, 1'b0, 8'h75);
        applyStimulus(1'b1, 1'b0, 8'h1C);
        applyStimulus(1'b1, 1'b0, 8'h36);
        checkOutput("t5_before", btn, 20'h10801);
        clear_all = 1'b1;
        ps2_key   = {~ps2_key[10], 1'b1, 1'b0, 8'h14};
        tick();
        clear_all = 1'b0;
        checkOutput("t5_clear_btn", btn, 20'h0);
        checkOutput("t5_clear_hit", {19'b0, key_hit}, 20'h0);
        tick();
        checkOutput("t5_consumed_btn", btn, 20'h0);
        checkOutput("t5_consumed_hit", {19'b0, key_hit}, 20'h0);
        applyStimulus(1'b1, 1'b0, 8'h14);
        checkOutput("t5_next_btn", btn, 20'h00010);
        checkOutput("t5_next_hit", {19'b0, key_hit}, 20'h1);
        applyStimulus(1'b0, 1'b0, 8'h14);

        $display("[TB] autofire on fireA");
        autofire  = 1'b1;
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h14);
`ifdef WILLIAMS_AUTOFIRE_EN
        checkOutput("t6_af_k1", btn, 20'h0);
        repeat (2) tick();
        checkOutput("t6_af_k3", btn, 20'h0);
        tick();
        checkOutput("t6_af_k4", btn, 20'h00010);
        repeat (3) tick();
        checkOutput("t6_af_k7", btn, 20'h00010);
        tick();
        checkOutput("t6_af_k8", btn, 20'h0);
        repeat (4) tick();
        checkOutput("t6_af_k12", btn, 20'h00010);
`else
        for (int i = 0; i < 12; i++) begin
            checkOutput("t6_steady", btn, 20'h00010);
            tick();
        end
`endif
        applyStimulus(1'b0, 1'b0, 8'h14);
        checkOutput("t6_release", btn, 20'h0);
        autofire = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
